// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes and latches hw interrupt levels, arbitrates them against INT/ERET
// requests and hands one request at a time to the scheduler. Optional macro INT_CTRL_ACK_TIMEOUT_EN.
module int_ctrl (
    input  logic        schi_clk,
    input  logic        schi_rst,
    input  logic [3:0]  hw_irq,
    input  logic        soft_int_req,
    input  logic [3:0]  soft_int_id,
    input  logic        eret_req,
    input  logic [15:0] cur_pc,
    input  logic        mask_we,
    input  logic [3:0]  mask_wdata,
    input  logic        int_ack,
    output logic        int_o,
    output logic [3:0]  int_id_o,
    output logic [15:0] epc_o,
    output logic        in_handler_o,
    output logic [3:0]  pending_o,
    output logic        err_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_HANDLER = 2'd2;
    localparam logic [3:0] ID_ERET    = 4'hF;

    logic [1:0]  state_reg, state_next;
    logic [3:0]  id_reg, id_next;
    logic [15:0] epc_reg, epc_next;
    logic        err_reg, err_next;
    logic [3:0]  mask_reg;
    logic [3:0]  pending_reg, pending_next;
    logic [3:0]  pending_clr, pending_set;
    logic [3:0]  hw_edge;
    logic [3:0]  hw_ready;
    logic [1:0]  hw_sel_idx;
    logic        hw_any;
    logic        soft_valid;
    logic        ack_timeout;

    // Per-source 2-flop synchronizer plus a delayed copy for rising-edge detection.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_irq
            logic sync1_reg, sync2_reg, sync_prev_reg;

            always_ff @(posedge schi_clk or negedge schi_rst) begin
                if (!schi_rst) begin
                    sync1_reg     <= 1'b0;
                    sync2_reg     <= 1'b0;
                    sync_prev_reg <= 1'b0;
                end else begin
                    sync1_reg     <= hw_irq[gi];
                    sync2_reg     <= sync1_reg;
                    sync_prev_reg <= sync2_reg;
                end
            end

            assign hw_edge[gi]      = sync2_reg & ~sync_prev_reg;
            assign pending_next[gi] = (pending_reg[gi] & ~pending_clr[gi]) | pending_set[gi] | hw_edge[gi];
        end
    endgenerate

    // Lowest set index wins among enabled pending sources.
    always_comb begin
        hw_ready   = pending_reg & mask_reg;
        hw_any     = |hw_ready;
        hw_sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hw_ready[i]) begin
                hw_sel_idx = i[1:0];
            end
        end
    end

`ifdef INT_CTRL_ACK_TIMEOUT_EN
    logic [3:0] ack_cnt_reg, ack_cnt_next;

    always_comb begin
        ack_cnt_next = 4'd0;
        if (state_reg == ST_REQ && !int_ack) begin
            ack_cnt_next = ack_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge schi_clk or negedge schi_rst) begin
        if (!schi_rst) begin
            ack_cnt_reg <= 4'd0;
        end else begin
            ack_cnt_reg <= ack_cnt_next;
        end
    end

    assign ack_timeout = (state_reg == ST_REQ) && !int_ack && (ack_cnt_reg == 4'hF);
`else
    assign ack_timeout = 1'b0;
`endif

    assign soft_valid = soft_int_req && (soft_int_id != ID_ERET);

    always_comb begin
        state_next  = state_reg;
        id_next     = id_reg;
        epc_next    = epc_reg;
        err_next    = err_reg;
        pending_clr = 4'd0;
        pending_set = 4'd0;

        if (soft_int_req && soft_int_id == ID_ERET) begin
            err_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (eret_req) begin
                    err_next = 1'b1;
                end
                if (soft_valid) begin
                    id_next    = soft_int_id;
                    epc_next   = cur_pc;
                    state_next = ST_REQ;
                end else if (hw_any) begin
                    pending_clr = 4'b0001 << hw_sel_idx;
                    id_next     = {2'b10, hw_sel_idx};
                    epc_next    = cur_pc;
                    state_next  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (soft_int_req) begin
                    err_next = 1'b1;
                end
                if (int_ack) begin
                    state_next = (id_reg == ID_ERET) ? ST_IDLE : ST_HANDLER;
                end else if (ack_timeout) begin
                    // Abandoned hw dispatch goes back into pending so it is not lost.
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                    if (id_reg[3:2] == 2'b10) begin
                        pending_set = 4'b0001 << id_reg[1:0];
                    end
                end
            end
            ST_HANDLER: begin
                if (soft_int_req) begin
                    err_next = 1'b1;
                end
                if (eret_req) begin
                    id_next    = ID_ERET;
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge schi_clk or negedge schi_rst) begin
        if (!schi_rst) begin
            state_reg   <= ST_IDLE;
            id_reg      <= 4'd0;
            epc_reg     <= 16'd0;
            err_reg     <= 1'b0;
            mask_reg    <= 4'hF;
            pending_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            id_reg      <= id_next;
            epc_reg     <= epc_next;
            err_reg     <= err_next;
            pending_reg <= pending_next;
            if (mask_we) begin
                mask_reg <= mask_wdata;
            end
        end
    end

    assign int_o        = (state_reg == ST_REQ);
    assign in_handler_o = (state_reg == ST_HANDLER);
    assign int_id_o     = id_reg;
    assign epc_o        = epc_reg;
    assign pending_o    = pending_reg;
    assign err_o        = err_reg;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have port: schi_clk  in  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have port: schi_rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: hw_irq  in  4  asynchronous level interrupt sources; bit 0 has highest priority.
REQ-004 SHALL have port: soft_int_req  in  1  one-cycle pulse from decode for an INT instruction.
REQ-005 SHALL have port: soft_int_id  in  4  INT operand; valid with soft_int_req; 4'hF reserved.
REQ-006 SHALL have port: eret_req  in  1  one-cycle pulse from decode for ERET.
REQ-007 SHALL have port: cur_pc  in  16  PC of the instruction raising the request.
REQ-008 SHALL have port: mask_we / mask_wdata  in  1 / 4  mask register write strobe and data; bit=1 enables.
REQ-009 SHALL have port: int_ack  in  1  scheduler has redirected PC; driven from scheduler interrupt_set_pc.
REQ-010 SHALL have port: int_o  out  1  request level to scheduler schi_int.
REQ-011 SHALL have port: int_id_o  out  4  request id to scheduler schi_int_id.
REQ-012 SHALL have port: epc_o  out  16  faulting PC to scheduler schi_epc.
REQ-013 SHALL have port: in_handler_o / pending_o / err_o  out  1 / 4 / 1  handler active, latched hw pending bits, sticky error.

Function
REQ-014 SHALL pass hw_irq through a 2-flop synchronizer; a rising edge on a synchronized bit sets pending[i] on the following cycle.
REQ-015 SHALL have three states: IDLE, REQ, HANDLER.
REQ-016 IDLE: on soft_int_req with id != 4'hF, SHALL latch id/cur_pc and go to REQ.
REQ-017 IDLE: with no soft request and (pending & mask) != 0, SHALL select the lowest set index i, clear pending[i], set id = 4'h8+i, latch cur_pc, go to REQ.
REQ-018 Soft request and hw pending in the same cycle SHALL resolve to soft; hw stays pending.
REQ-019 REQ: SHALL hold int_o=1 with stable id/epc until int_ack=1, then drop int_o next cycle and enter HANDLER (or IDLE when id=4'hF).
REQ-020 HANDLER: in_handler_o=1; new hw edges SHALL accumulate in pending_o and are not dispatched (no nesting).
REQ-021 HANDLER: eret_req SHALL set id=4'hF, epc unchanged, and enter REQ.
REQ-022 eret_req in IDLE, soft_int_req in HANDLER or REQ, or soft_int_id=4'hF SHALL be ignored and set err_o (sticky until reset).
REQ-023 A mask write SHALL take effect the cycle after mask_we; masked bits stay pending and dispatch when unmasked.
REQ-024 A hw edge on a bit whose pending bit is already set SHALL be merged (no counting).
REQ-025 Latency: IDLE request to int_o=1 SHALL be exactly 1 cycle; sync hw edge to int_o=1 SHALL be 2 cycles when IDLE and unmasked.

Reset
REQ-026 On schi_rst=0 SHALL immediately force: state IDLE, int_o 0, int_id_o 0, epc_o 0, pending_o 0, mask 4'hF, err_o 0, in_handler_o 0, synchronizer flops 0.
REQ-027 Reset during REQ or HANDLER SHALL discard the in-flight request with no int_o pulse after release.

Configuration
REQ-028 With INT_CTRL_ACK_TIMEOUT_EN defined, a 4-bit counter SHALL abort REQ after 16 cycles without int_ack: int_o drops, err_o sets, state returns to IDLE (hw source re-pended).
REQ-029 Without INT_CTRL_ACK_TIMEOUT_EN, REQ SHALL wait indefinitely for int_ack and no counter is built.

Verification
REQ-030 soft_int_req, id=4'h3, cur_pc=16'h0120 in IDLE -> next cycle int_o=1, int_id_o=3, epc_o=16'h0120; ack -> in_handler_o=1.
REQ-031 hw_irq=4'b0110 rising together, mask 4'hF -> dispatch id 4'h9 first, pending_o=4'b0100; after ERET and ack, dispatch id 4'hA.
REQ-032 In HANDLER, eret_req -> int_o=1, id=4'hF, epc_o unchanged; ack -> IDLE, in_handler_o=0.
REQ-033 mask_wdata=4'b1110, hw_irq[0] edge -> pending_o[0]=1, no int_o; write mask 4'hF -> int_o=1, id 4'h8 two cycles later.
REQ-034 eret_req in IDLE -> err_o=1, no int_o; reset asserted mid-REQ -> all outputs 0 immediately, mask=4'hF.
REQ-035 With INT_CTRL_ACK_TIMEOUT_EN, hold int_ack=0 after request -> int_o drops after 16 cycles, err_o=1, state IDLE.
